// File: rtl/frame_burst_reader.sv
// Burst-read initiator: splits one frame into bursts of up to BURST_LEN words,
// issues each only when the downstream FIFO can take all of it, and forwards the read data.
module frame_burst_reader #(
    parameter int MEM_DATA_BITS = 32,
    parameter int BURST_LEN     = 128,
    parameter int FRAME_WORDS   = 307200
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic [23:0]              base_addr,
    input  logic [10:0]              fifo_free,
    output logic                     rd_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [23:0]              rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic                     rd_burst_finish,
    output logic                     fifo_wr_en,
    output logic [MEM_DATA_BITS-1:0] fifo_wr_data,
    output logic                     frame_busy,
    output logic                     frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [9:0]  MAX_LEN = 10'(BURST_LEN);
    localparam logic [23:0] TOTAL   = 24'(FRAME_WORDS);

    logic [1:0]               state_q, state_d;
    logic [23:0]              next_addr_q, next_addr_d;
    logic [23:0]              remaining_q, remaining_d;
    logic                     req_q, req_d;
    logic [9:0]               len_q, len_d;
    logic [23:0]              addr_q, addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     wr_en_q;
    logic [MEM_DATA_BITS-1:0] wr_data_q;

    logic [9:0]  cur_len;
    logic [23:0] remaining_next;

    always_comb begin
        cur_len        = (remaining_q < {14'd0, MAX_LEN}) ? remaining_q[9:0] : MAX_LEN;
        // len_q holds cur_len for the whole REQ phase since remaining is frozen there
        remaining_next = remaining_q - {14'd0, len_q};

        state_d     = state_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        req_d       = req_q;
        len_d       = len_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    next_addr_d = base_addr;
                    remaining_d = TOTAL;
                    busy_d      = 1'b1;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if ({1'b0, cur_len} <= fifo_free) begin
                    addr_d  = next_addr_q;
                    len_d   = cur_len;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_burst_finish) begin
                    req_d       = 1'b0;
                    next_addr_d = next_addr_q + {14'd0, len_q};
                    remaining_d = remaining_next;
                    state_d     = (remaining_next == 24'd0) ? S_DONE : S_CHECK;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            next_addr_q <= 24'd0;
            remaining_q <= 24'd0;
            req_q       <= 1'b0;
            len_q       <= 10'd0;
            addr_q      <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            req_q       <= req_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Data path runs in every state; word counting is left to the controller's finish pulse
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= rd_burst_data_valid;
            wr_data_q <= rd_burst_data;
        end
    end

    assign rd_burst_req  = req_q;
    assign rd_burst_len  = len_q;
    assign rd_burst_addr = addr_q;
    assign fifo_wr_en    = wr_en_q;
    assign fifo_wr_data  = wr_data_q;
    assign frame_busy    = busy_q;
    assign frame_done    = done_q;

endmodule
